rr_req_queue: RTL and testbench

Per-port request buffering stage that sits directly upstream of rr_arbiter. It holds incoming transactions in one small FIFO per port and drives the arbiter's req vector from FIFO occupancy. It consumes the arbiter's one-hot grant to pop the granted port's head into a single registered output with a valid/ready handshake. Together with rr_arbiter it forms an N:1 arbitrated mux.

---
 rtl/rr_req_queue.sv | 136 +++++++++++++
 tb/tb_rr_req_queue.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_req_queue.sv
// rr_req_queue: per-port request FIFOs feeding an external round-robin arbiter, popped into one registered output.
// Optional build macro RR_REQ_QUEUE_ERR_EN adds a sticky err output for bad grants and pushes while full.

module rr_req_fifo #(
    parameter int DATA  = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA-1:0]        wdata,
    output logic [DATA-1:0]        head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];
endmodule

module rr_req_queue #(
    parameter int PORT  = 4,
    parameter int IDX   = $clog2(PORT),
    parameter int DATA  = 32,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_,
    input  logic [PORT-1:0]      in_valid,
    input  logic [PORT*DATA-1:0] in_data,
    output logic [PORT-1:0]      in_ready,
    output logic [PORT-1:0]      req,
    input  logic [PORT-1:0]      grant,
    output logic                 out_valid,
    output logic [DATA-1:0]      out_data,
    output logic [IDX-1:0]       out_port,
    input  logic                 out_ready
`ifdef RR_REQ_QUEUE_ERR_EN
    ,
    output logic                 err
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PORT-1:0][CW-1:0]   count;
    logic [PORT-1:0][DATA-1:0] head;
    logic [PORT-1:0]           push, pop, nonempty;
    logic                      slot_free, grant_onehot, pop_ok;
    logic [IDX-1:0]            gidx;
    logic [DATA-1:0]           ghead;

    assign slot_free    = ~out_valid | out_ready;
    assign req          = nonempty & {PORT{slot_free}};
    assign grant_onehot = (grant != '0) && ((grant & (grant - 1'b1)) == '0);
    // A grant only pops if it names exactly one port that is actually requesting.
    assign pop_ok       = grant_onehot && ((grant & ~req) == '0);

    for (genvar g = 0; g < PORT; g++) begin : g_port
        assign in_ready[g] = (count[g] != CW'(DEPTH));
        assign nonempty[g] = (count[g] != '0);
        assign push[g]     = in_valid[g] & in_ready[g];
        assign pop[g]      = pop_ok & grant[g];

        rr_req_fifo #(.DATA(DATA), .DEPTH(DEPTH)) u_fifo (
            .clk    (clk),
            .reset_ (reset_),
            .push   (push[g]),
            .pop    (pop[g]),
            .wdata  (in_data[g*DATA +: DATA]),
            .head   (head[g]),
            .count  (count[g])
        );
    end

    always_comb begin
        gidx  = '0;
        ghead = '0;
        for (int i = 0; i < PORT; i++) begin
            if (grant[i]) begin
                gidx  = IDX'(i);
                ghead = head[i];
            end
        end
    end

    // A pop refills the slot in the same edge it drains, giving one transfer per cycle.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_port  <= '0;
        end else if (pop_ok) begin
            out_valid <= 1'b1;
            out_data  <= ghead;
            out_port  <= gidx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef RR_REQ_QUEUE_ERR_EN
    logic bad_grant, bad_push;

    assign bad_grant = (grant != '0) && !pop_ok;
    assign bad_push  = |(in_valid & ~in_ready);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_)                    err <= 1'b0;
        else if (bad_grant || bad_push) err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_rr_req_queue.sv
// Bench for rr_req_queue: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_rr_req_queue;
    localparam int PORT  = 4;
    localparam int DATA  = 32;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset_ = 1'b0;
    logic [3:0]   in_valid = '0;
    logic [127:0] in_data = '0;
    logic [3:0]   in_ready, req;
    logic [3:0]   grant = '0;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_port;
    logic         out_ready = 1'b0;
`ifdef RR_REQ_QUEUE_ERR_EN
    logic         err;
`endif

    always #5 clk = ~clk;

    rr_req_queue #(.PORT(PORT), .DATA(DATA), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req       (req),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_port  (out_port),
        .out_ready (out_ready)
`ifdef RR_REQ_QUEUE_ERR_EN
        ,
        .err       (err)
`endif
    );

    // Reference model: one queue per port plus the held output and an arbiter pointer.
    typedef logic [31:0] q_t [$];
    q_t          mq [4];
    logic        mov, merr;
    logic [31:0] mod;
    logic [1:0]  mop;
    int          rrptr;
    int          checks = 0;
    int          passed = 0;

    function automatic logic [3:0] mreq_f();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (mq[i].size() != 0) && (!mov || out_ready);
        return r;
    endfunction

    function automatic logic [3:0] mready_f();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (mq[i].size() < DEPTH);
        return r;
    endfunction

    function automatic logic [3:0] arb_f(input logic [3:0] r);
        for (int off = 0; off < 4; off++) begin
            int idx;
            idx = (rrptr + off) % 4;
            if (r[idx]) return 4'(1 << idx);
        end
        return 4'b0000;
    endfunction

    // Advance one clock; the model applies the same edge using pre-edge state and inputs.
    task automatic step(input bit use_arb);
        logic [3:0] r, acc;
        bit         popok;
        int         k;
        r = mreq_f();
        if (use_arb) grant = arb_f(r);
        acc   = mready_f() & in_valid;
        popok = $onehot(grant) && ((grant & ~r) == 4'b0000);
        if ((grant != 4'b0000 && !popok) || ((in_valid & ~mready_f()) != 4'b0000)) merr = 1'b1;
        k = 0;
        for (int i = 0; i < 4; i++) if (grant[i]) k = i;
        @(posedge clk);
        if (popok) begin
            mod   = mq[k].pop_front();
            mop   = 2'(k);
            mov   = 1'b1;
            rrptr = (k + 1) % 4;
        end else if (mov && out_ready) begin
            mov = 1'b0;
        end
        for (int i = 0; i < 4; i++) if (acc[i]) mq[i].push_back(in_data[i*32 +: 32]);
        #1;
    endtask

    task automatic apply_reset();
        reset_    = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        grant     = '0;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) mq[i].delete();
        mov = 1'b0; mod = '0; mop = '0; merr = 1'b0; rrptr = 0;
        reset_ = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passed++;
        checks++; if (req !== 4'b0000) $display("FAIL reset_req got %b exp 0000", req); else passed++;
        checks++; if (in_ready !== 4'b1111) $display("FAIL reset_in_ready got %b exp 1111", in_ready); else passed++;
        checks++; if (out_data !== 32'h0 || out_port !== 2'd0)
            $display("FAIL reset_out_regs got %h/%0d exp 0/0", out_data, out_port); else passed++;
        apply_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 4'b1111;
            for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = $urandom;
            step(1'b1);
        end
        in_valid = '0;
        grant    = '0;
        checks++; if (out_valid !== 1'b1) $display("FAIL midburst_pre got %b exp 1", out_valid); else passed++;
        #3 reset_ = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL async_out_valid got %b exp 0", out_valid); else passed++;
        checks++; if (req !== 4'b0000) $display("FAIL async_req got %b exp 0000", req); else passed++;
        checks++; if (in_ready !== 4'b1111) $display("FAIL async_in_ready got %b exp 1111", in_ready); else passed++;
        apply_reset();
    endtask

    task automatic test_single_port();
        apply_reset();
        out_ready = 1'b1;
        in_valid  = 4'b0100;
        in_data[2*32 +: 32] = 32'hA5;
        step(1'b0);
        in_valid = '0;
        checks++; if (req !== 4'b0100) $display("FAIL single_req got %b exp 0100", req); else passed++;
        step(1'b1);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hA5 || out_port !== 2'd2)
            $display("FAIL single_out got v=%b d=%h p=%0d exp v=1 d=a5 p=2", out_valid, out_data, out_port); else passed++;
        grant = '0;
        step(1'b0);
        checks++; if (out_valid !== 1'b0) $display("FAIL single_drain got %b exp 0", out_valid); else passed++;
    endtask

    task automatic test_fairness();
        apply_reset();
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'h10 + i;
        step(1'b0);
        in_valid = '0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            checks++; if (out_valid !== 1'b1 || out_port !== 2'(i) || out_data !== 32'h10 + i)
                $display("FAIL fair_%0d got v=%b p=%0d d=%h exp v=1 p=%0d d=%h",
                         i, out_valid, out_port, out_data, i, 32'h10 + i); else passed++;
        end
        grant = '0;
    endtask

    task automatic test_full_backpressure();
        apply_reset();
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        in_data[0 +: 32] = 32'h77;
        step(1'b0);
        in_valid = '0;
        step(1'b1);
        for (int n = 0; n < 5; n++) begin
            in_valid = 4'b0010;
            in_data[32 +: 32] = 32'h100 + n;
            step(1'b1);
            if (n >= 3) begin
                checks++; if (in_ready !== 4'b1101) $display("FAIL full_in_ready_%0d got %b exp 1101", n, in_ready); else passed++;
            end
        end
        in_valid = '0;
        checks++; if (req !== 4'b0000) $display("FAIL full_req got %b exp 0000", req); else passed++;
        checks++; if (out_data !== 32'h77) $display("FAIL full_hold got %h exp 77", out_data); else passed++;
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step(1'b1);
            checks++; if (out_valid !== 1'b1 || out_port !== 2'd1 || out_data !== 32'h100 + n)
                $display("FAIL full_order_%0d got v=%b p=%0d d=%h exp v=1 p=1 d=%h",
                         n, out_valid, out_port, out_data, 32'h100 + n); else passed++;
        end
        step(1'b1);
        checks++; if (out_valid !== 1'b0) $display("FAIL full_dropped got %b exp 0", out_valid); else passed++;
        grant = '0;
    endtask

    task automatic test_same_cycle();
        apply_reset();
        out_ready = 1'b1;
        in_valid  = 4'b1000;
        in_data[3*32 +: 32] = 32'h31;
        step(1'b0);
        in_data[3*32 +: 32] = 32'h32;
        grant = 4'b1000;
        step(1'b0);
        in_valid = '0;
        checks++; if (out_data !== 32'h31 || out_port !== 2'd3) $display("FAIL same_old_head got %h/%0d exp 31/3", out_data, out_port); else passed++;
        checks++; if (req !== 4'b1000) $display("FAIL same_count got req %b exp 1000", req); else passed++;
        step(1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h32) $display("FAIL same_new_head got %b/%h exp 1/32", out_valid, out_data); else passed++;
        grant = '0;
        step(1'b0);
        checks++; if (req !== 4'b0000) $display("FAIL same_empty got %b exp 0000", req); else passed++;
    endtask

    task automatic test_invalid_grant();
        apply_reset();
        out_ready = 1'b1;
        in_valid  = 4'b0011;
        step(1'b0);
        in_valid = '0;
        checks++; if (req !== 4'b0011) $display("FAIL inv_req_pre got %b exp 0011", req); else passed++;
        grant = 4'b0011;
        step(1'b0);
        grant = '0;
        checks++; if (out_valid !== 1'b0 || req !== 4'b0011)
            $display("FAIL inv_no_pop got v=%b req=%b exp v=0 req=0011", out_valid, req); else passed++;
`ifdef RR_REQ_QUEUE_ERR_EN
        checks++; if (err !== 1'b1) $display("FAIL inv_err got %b exp 1", err); else passed++;
`endif
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid  = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                grant = 4'($urandom_range(0, 15));
                step(1'b0);
            end else begin
                step(1'b1);
            end
            checks++; if (req !== mreq_f()) $display("FAIL rnd_req c=%0d got %b exp %b", c, req, mreq_f()); else passed++;
            checks++; if (in_ready !== mready_f()) $display("FAIL rnd_in_ready c=%0d got %b exp %b", c, in_ready, mready_f()); else passed++;
            checks++; if (out_valid !== mov) $display("FAIL rnd_out_valid c=%0d got %b exp %b", c, out_valid, mov); else passed++;
            checks++; if (out_data !== mod || out_port !== mop)
                $display("FAIL rnd_out c=%0d got %h/%0d exp %h/%0d", c, out_data, out_port, mod, mop); else passed++;
`ifdef RR_REQ_QUEUE_ERR_EN
            checks++; if (err !== merr) $display("FAIL rnd_err c=%0d got %b exp %b", c, err, merr); else passed++;
`endif
        end
        grant = '0;
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_fairness();
        test_full_backpressure();
        test_same_cycle();
        test_invalid_grant();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
